pwm_cfg_sequencer: RTL and testbench

PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

---
 rtl/pwm_cfg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_sequencer.sv
// Per-channel PWM configuration sequencer: shadows period/duty/enable commands and
// applies them glitch-free at the generator's period boundary. Optional duty ramp: PWM_CFG_SEQ_RAMP_EN.
module pwm_cfg_sequencer #(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = 16,
    parameter int RAMP_STEP     = 1,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [CH_W-1:0]                   cmd_ch,
    input  logic                              cmd_en,
    input  logic [COUNTER_WIDTH-1:0]          cmd_period,
    input  logic [COUNTER_WIDTH-1:0]          cmd_duty,
    input  logic [NUM_CH-1:0]                 period_end,
    output logic [NUM_CH*COUNTER_WIDTH-1:0]   pwm_period,
    output logic [NUM_CH*COUNTER_WIDTH-1:0]   pwm_duty,
    output logic [NUM_CH-1:0]                 ch_enable,
    output logic [NUM_CH-1:0]                 pending,
    output logic [NUM_CH-1:0]                 update_done
);

    // state      | meaning
    // ST_IDLE    | no unapplied command, channel accepts a new one
    // ST_PENDING | shadow holds a command (or a ramp still in progress)
    typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} ch_state_t;

    localparam int W = COUNTER_WIDTH;

    if (RAMP_STEP < 1) begin : g_bad_step
        $error("RAMP_STEP must be at least 1");
    end

    ch_state_t          state_q [NUM_CH];
    ch_state_t          state_d [NUM_CH];

    logic [W-1:0]       period_q [NUM_CH];
    logic [W-1:0]       duty_q   [NUM_CH];
    logic [NUM_CH-1:0]  en_q;
    logic [NUM_CH-1:0]  done_q;

    logic [W-1:0]       sh_period [NUM_CH];
    logic [W-1:0]       sh_duty   [NUM_CH];
    logic [NUM_CH-1:0]  sh_en;

    logic [NUM_CH-1:0]  accept;
    logic [NUM_CH-1:0]  apply_now;
    logic [NUM_CH-1:0]  finish;
    logic [W-1:0]       duty_next [NUM_CH];
    logic [W-1:0]       clamp_duty;
    logic               ch_valid;

    assign ch_valid   = (int'(cmd_ch) < NUM_CH);
    assign clamp_duty = (cmd_duty > cmd_period) ? cmd_period : cmd_duty;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
        end
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE:    if (accept[i]) state_d[i] = ST_PENDING;
                ST_PENDING: if (finish[i]) state_d[i] = ST_IDLE;
                default:    state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        cmd_ready = 1'b0;
        if (ch_valid) cmd_ready = (state_q[cmd_ch] == ST_IDLE);
        for (int i = 0; i < NUM_CH; i++) begin
            accept[i]    = cmd_valid && cmd_ready && (int'(cmd_ch) == i);
            apply_now[i] = (state_q[i] == ST_PENDING) && (!en_q[i] || period_end[i]);
            pending[i]   = (state_q[i] == ST_PENDING);
`ifdef PWM_CFG_SEQ_RAMP_EN
            duty_next[i] = duty_q[i];
            finish[i]    = 1'b0;
            if (apply_now[i]) begin
                if (!sh_en[i]) begin
                    // disable jumps straight to the shadow values, no ramp-down
                    duty_next[i] = sh_duty[i];
                    finish[i]    = 1'b1;
                end else if (!en_q[i]) begin
                    duty_next[i] = '0;
                    finish[i]    = (sh_duty[i] == '0);
                end else begin
                    if (duty_q[i] < sh_duty[i]) begin
                        if ((sh_duty[i] - duty_q[i]) <= W'(RAMP_STEP))
                            duty_next[i] = sh_duty[i];
                        else
                            duty_next[i] = duty_q[i] + W'(RAMP_STEP);
                    end else begin
                        if ((duty_q[i] - sh_duty[i]) <= W'(RAMP_STEP))
                            duty_next[i] = sh_duty[i];
                        else
                            duty_next[i] = duty_q[i] - W'(RAMP_STEP);
                    end
                    finish[i] = (duty_next[i] == sh_duty[i]);
                end
            end
`else
            duty_next[i] = sh_duty[i];
            finish[i]    = apply_now[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_period[i] <= '0;
                sh_duty[i]   <= '0;
            end
            sh_en <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    sh_period[i] <= cmd_period;
                    sh_duty[i]   <= clamp_duty;
                    sh_en[i]     <= cmd_en;
                end
            end
        end
    end

    // Period, duty and enable move together so the generator never sees a mixed config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                duty_q[i]   <= '0;
            end
            en_q   <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                done_q[i] <= apply_now[i] && finish[i];
                if (apply_now[i]) begin
                    period_q[i] <= sh_period[i];
                    duty_q[i]   <= duty_next[i];
                    en_q[i]     <= sh_en[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign pwm_period[g*W +: W] = period_q[g];
        assign pwm_duty[g*W +: W]   = duty_q[g];
    end

    assign ch_enable   = en_q;
    assign update_done = done_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer; ramp scenario is compiled in when PWM_CFG_SEQ_RAMP_EN is defined.
module tb_pwm_cfg_sequencer;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_ch;
    logic            cmd_en;
    logic [W-1:0]    cmd_period;
    logic [W-1:0]    cmd_duty;
    logic [NCH-1:0]  period_end;
    logic [NCH*W-1:0] pwm_period;
    logic [NCH*W-1:0] pwm_duty;
    logic [NCH-1:0]  ch_enable;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  update_done;

    int total  = 0;
    int passed = 0;

    pwm_cfg_sequencer #(.NUM_CH(NCH), .COUNTER_WIDTH(W), .RAMP_STEP(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_en(cmd_en), .cmd_period(cmd_period), .cmd_duty(cmd_duty),
        .period_end(period_end), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
        .ch_enable(ch_enable), .pending(pending), .update_done(update_done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] per(input int i);
        return pwm_period[i*W +: W];
    endfunction

    function automatic logic [W-1:0] dty(input int i);
        return pwm_duty[i*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic en, input int p, input int d);
        cmd_valid  = 1'b1;
        cmd_ch     = 2'(ch);
        cmd_en     = en;
        cmd_period = W'(p);
        cmd_duty   = W'(d);
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        period_end = m;
        step();
        period_end = '0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_en = 1'b0;
        cmd_period = '0; cmd_duty = '0; period_end = '0;
        #12;
        chk("rst_period", pwm_period, 0);
        chk("rst_duty", pwm_duty, 0);
        chk("rst_enable", ch_enable, 0);
        chk("rst_pending", pending, 0);
        chk("rst_done", update_done, 0);
        chk("rst_ready", cmd_ready, 1);
        step();
        rst_n = 1'b1;
        step();

`ifndef PWM_CFG_SEQ_RAMP_EN
        // ch0 from disabled: applies the cycle after accept
        send(0, 1'b1, 100, 25);
        chk("t1_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("t1_pending", pending, 4'b0001);
        chk("t1_not_yet", ch_enable, 0);
        step();
        chk("t1_period", per(0), 100);
        chk("t1_duty", dty(0), 25);
        chk("t1_enable", ch_enable, 4'b0001);
        chk("t1_done", update_done, 4'b0001);
        chk("t1_pend_clr", pending, 0);
        step();
        chk("t1_done_1cyc", update_done, 0);

        // ch0 running: waits for period_end
        send(0, 1'b1, 100, 60);
        step();
        cmd_valid = 1'b0;
        cmd_ch = 2'd0;
        for (int k = 0; k < 40; k++) begin
            chk("t2_hold_duty", dty(0), 25);
            chk("t2_ready_low", cmd_ready, 0);
            step();
        end
        pulse(4'b0001);
        chk("t2_duty", dty(0), 60);
        chk("t2_done", update_done, 4'b0001);
        chk("t2_pend_clr", pending, 0);

        // duty clamp to period
        send(0, 1'b1, 50, 80);
        step();
        cmd_valid = 1'b0;
        step();
        pulse(4'b0001);
        chk("t3_period", per(0), 50);
        chk("t3_clamp", dty(0), 50);

        // bring up ch1 and ch2
        send(1, 1'b1, 200, 10);
        step();
        send(2, 1'b1, 300, 30);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t4_up_en", ch_enable, 4'b0111);
        chk("t4_up_d1", dty(1), 10);
        chk("t4_up_d2", dty(2), 30);

        // accept coincident with period_end must not apply
        send(1, 1'b1, 200, 99);
        period_end = 4'b0110;
        step();
        period_end = '0;
        chk("t4_coinc_pend", pending, 4'b0010);
        chk("t4_coinc_hold", dty(1), 10);
        send(2, 1'b1, 300, 77);
        step();
        cmd_valid = 1'b0;
        chk("t4_pend_both", pending, 4'b0110);
        chk("t4_hold2", dty(2), 30);
        pulse(4'b0110);
        chk("t4_d1", dty(1), 99);
        chk("t4_d2", dty(2), 77);
        chk("t4_done_both", update_done, 4'b0110);
        chk("t4_pend_clr", pending, 0);

        // disable on running channel waits for period_end
        send(2, 1'b0, 300, 5);
        step();
        cmd_valid = 1'b0;
        pulse(4'b0001);
        chk("t5_still_en", ch_enable[2], 1);
        chk("t5_stray_pe", pending, 4'b0100);
        pulse(4'b0100);
        chk("t5_disabled", ch_enable, 4'b0011);
        chk("t5_duty", dty(2), 5);

        // ch3 duty == period boundary
        send(3, 1'b1, 7, 7);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t6_duty_eq", dty(3), 7);

        // reset while ch3 pending
        send(3, 1'b1, 7, 3);
        step();
        cmd_valid = 1'b0;
        chk("t7_pending", pending, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_period", pwm_period, 0);
        chk("t7_async_duty", pwm_duty, 0);
        chk("t7_async_en", ch_enable, 0);
        chk("t7_async_pend", pending, 0);
        step();
        rst_n = 1'b1;
        period_end = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t7_no_done", update_done, 0);
            chk("t7_no_pend", pending, 0);
        end
        period_end = '0;
`else
        // ramp: enable ch0 with duty 0, then ramp to 35 in steps of 10
        send(0, 1'b1, 100, 0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("r_en", ch_enable, 4'b0001);
        chk("r_done0", update_done, 4'b0001);
        send(0, 1'b1, 100, 35);
        step();
        cmd_valid = 1'b0;
        pulse(4'b0001);
        chk("r_d10", dty(0), 10);
        chk("r_nd10", update_done, 0);
        chk("r_p10", pending, 4'b0001);
        step();
        pulse(4'b0001);
        chk("r_d20", dty(0), 20);
        step();
        pulse(4'b0001);
        chk("r_d30", dty(0), 30);
        chk("r_nd30", update_done, 0);
        step();
        pulse(4'b0001);
        chk("r_d35", dty(0), 35);
        chk("r_done35", update_done, 4'b0001);
        chk("r_pclr", pending, 0);

        // disable applies at once, no ramp down
        send(0, 1'b0, 100, 5);
        step();
        cmd_valid = 1'b0;
        pulse(4'b0001);
        chk("r_dis_en", ch_enable, 0);
        chk("r_dis_duty", dty(0), 5);
        chk("r_dis_done", update_done, 4'b0001);

        // from disabled: start at 0 then ramp to 15
        send(0, 1'b1, 100, 15);
        step();
        cmd_valid = 1'b0;
        step();
        chk("r_st_en", ch_enable, 4'b0001);
        chk("r_st_d0", dty(0), 0);
        chk("r_st_pend", pending, 4'b0001);
        pulse(4'b0001);
        chk("r_st_d10", dty(0), 10);
        pulse(4'b0001);
        chk("r_st_d15", dty(0), 15);
        chk("r_st_done", update_done, 4'b0001);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
